// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/execute/writeback sequencer
//
// Purpose: drives a 16-bit register/ALU datapath one instruction at a time.
// Each instruction is fetched over a req/ack handshake and latched into IR.
// It is then decoded into register selects, ALU op and write enable.
// The block also tracks the PC, counts retired ALU instructions, and flags
// illegal opcodes and fetch timeouts.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-low reset
//   i_run          start pulse, only looked at in IDLE
//   i_imem_ack     instruction memory ack, i_ins_in valid while high
//   i_ins_in[15:0] instruction word from memory
//   o_pc[7:0]      current PC / instruction memory address
//   o_imem_req     fetch request
//   o_read_reg1    IR[8:6]
//   o_read_reg2    IR[5:3]
//   o_write_reg    IR[2:0]
//   o_alu_op[2:0]  ALU operation of the current instruction
//   o_wr_en        register-file write enable (WB cycle only)
//   o_busy         high in FETCH/DECODE/EXEC/WB
//   o_halted       high in HALT
//   o_err_illegal  sticky illegal-opcode flag
//   o_err_timeout  sticky fetch-timeout flag
//   o_retired      saturating count of retired ALU instructions

module multicycle_ctrl #(
   parameter logic [7:0]  START_PC      = 8'h00,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_run,
   input  logic        i_imem_ack,
   input  logic [15:0] i_ins_in,
   output logic [7:0]  o_pc,
   output logic        o_imem_req,
   output logic [2:0]  o_read_reg1,
   output logic [2:0]  o_read_reg2,
   output logic [2:0]  o_write_reg,
   output logic [2:0]  o_alu_op,
   output logic        o_wr_en,
   output logic        o_busy,
   output logic        o_halted,
   output logic        o_err_illegal,
   output logic        o_err_timeout,
   output logic [15:0] o_retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_NOP  = 7'h00;
   localparam logic [6:0] OP_HALT = 7'h7F;
   // Last count value before the timeout fires; the counter holds the number
   // of FETCH cycles already spent without an ack.
   localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t      r_state;
   logic [15:0] r_ir;
   logic [7:0]  r_pc;
   logic [7:0]  r_to_cnt;
   logic [2:0]  r_alu_op;
   logic        r_wr_en;
   logic        r_imem_req;
   logic        r_busy;
   logic        r_halted;
   logic        r_err_illegal;
   logic        r_err_timeout;
   logic [15:0] r_retired;

   logic [6:0]  w_opcode;
   logic        w_is_alu;
   logic [2:0]  w_alu_dec;

   assign w_opcode = r_ir[15:9];

   always_comb begin
      w_is_alu  = 1'b1;
      w_alu_dec = 3'd0;
      case (w_opcode)
         7'h01:   w_alu_dec = 3'd0;
         7'h02:   w_alu_dec = 3'd1;
         7'h03:   w_alu_dec = 3'd2;
         7'h04:   w_alu_dec = 3'd3;
         7'h05:   w_alu_dec = 3'd4;
         default: w_is_alu  = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_ir          <= 16'h0000;
         r_pc          <= START_PC;
         r_to_cnt      <= 8'd0;
         r_alu_op      <= 3'd0;
         r_wr_en       <= 1'b0;
         r_imem_req    <= 1'b0;
         r_busy        <= 1'b0;
         r_halted      <= 1'b0;
         r_err_illegal <= 1'b0;
         r_err_timeout <= 1'b0;
         r_retired     <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_run) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end

            S_FETCH: begin
               // An ack always beats a timeout landing in the same cycle.
               if (i_imem_ack) begin
                  r_ir       <= i_ins_in;
                  r_to_cnt   <= 8'd0;
                  r_imem_req <= 1'b0;
                  r_state    <= S_DECODE;
               end else if (r_to_cnt == TO_LAST) begin
                  r_to_cnt      <= 8'd0;
                  r_err_timeout <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_busy        <= 1'b0;
                  r_halted      <= 1'b1;
                  r_state       <= S_HALT;
               end else begin
                  r_to_cnt <= r_to_cnt + 8'd1;
               end
            end

            S_DECODE: begin
               if (w_is_alu) begin
                  r_alu_op <= w_alu_dec;
                  r_state  <= S_EXEC;
               end else if (w_opcode == OP_HALT) begin
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  // NOP and illegal opcodes both just step the PC.
                  if (w_opcode != OP_NOP) begin
                     r_err_illegal <= 1'b1;
                  end
                  r_pc       <= r_pc + 8'd1;
                  r_imem_req <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end

            S_EXEC: begin
               // Registered wr_en: setting it here makes it high for WB only.
               r_wr_en <= 1'b1;
               r_state <= S_WB;
            end

            S_WB: begin
               r_wr_en    <= 1'b0;
               r_pc       <= r_pc + 8'd1;
               if (r_retired != 16'hFFFF) begin
                  r_retired <= r_retired + 16'd1;
               end
               r_imem_req <= 1'b1;
               r_state    <= S_FETCH;
            end

            S_HALT: begin
               r_imem_req <= 1'b0;
               r_wr_en    <= 1'b0;
            end

            default: begin
               r_state    <= S_IDLE;
               r_imem_req <= 1'b0;
               r_wr_en    <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign o_pc          = r_pc;
   assign o_imem_req    = r_imem_req;
   assign o_read_reg1   = r_ir[8:6];
   assign o_read_reg2   = r_ir[5:3];
   assign o_write_reg   = r_ir[2:0];
   assign o_alu_op      = r_alu_op;
   assign o_wr_en       = r_wr_en;
   assign o_busy        = r_busy;
   assign o_halted      = r_halted;
   assign o_err_illegal = r_err_illegal;
   assign o_err_timeout = r_err_timeout;
   assign o_retired     = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed bench for multicycle_ctrl

module tb_multicycle_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_run;
   logic        i_imem_ack;
   logic [15:0] i_ins_in;
   logic [7:0]  o_pc;
   logic        o_imem_req;
   logic [2:0]  o_read_reg1;
   logic [2:0]  o_read_reg2;
   logic [2:0]  o_write_reg;
   logic [2:0]  o_alu_op;
   logic        o_wr_en;
   logic        o_busy;
   logic        o_halted;
   logic        o_err_illegal;
   logic        o_err_timeout;
   logic [15:0] o_retired;

   int nvec = 0;
   int nmis = 0;

   logic [15:0] mem [256];
   logic        mem_on    = 1'b1;
   int          ack_delay = 0;

   int          wr_count    = 0;
   logic [2:0]  last_wr_alu = 3'd0;
   logic [2:0]  last_wr_reg = 3'd0;

   localparam logic [15:0] I_ADD  = 16'h0253;
   localparam logic [15:0] I_SUB  = 16'h052E;
   localparam logic [15:0] I_NOP  = 16'h0000;
   localparam logic [15:0] I_XOR  = 16'h0BC1;
   localparam logic [15:0] I_HALT = 16'hFE00;
   localparam logic [15:0] I_ILL  = 16'h8000;

   multicycle_ctrl #(.START_PC(8'h00), .FETCH_TIMEOUT(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run),
      .i_imem_ack(i_imem_ack), .i_ins_in(i_ins_in),
      .o_pc(o_pc), .o_imem_req(o_imem_req),
      .o_read_reg1(o_read_reg1), .o_read_reg2(o_read_reg2), .o_write_reg(o_write_reg),
      .o_alu_op(o_alu_op), .o_wr_en(o_wr_en), .o_busy(o_busy), .o_halted(o_halted),
      .o_err_illegal(o_err_illegal), .o_err_timeout(o_err_timeout), .o_retired(o_retired)
   );

   always #5 i_clk = ~i_clk;

   // Instruction memory: acks after ack_delay waiting cycles of a request.
   initial begin
      int waited;
      waited     = 0;
      i_imem_ack = 1'b0;
      i_ins_in   = 16'h0000;
      forever begin
         @(negedge i_clk);
         if (mem_on && o_imem_req) begin
            if (waited == ack_delay) begin
               i_imem_ack = 1'b1;
               i_ins_in   = mem[o_pc];
               waited     = 0;
            end else begin
               i_imem_ack = 1'b0;
               waited++;
            end
         end else begin
            i_imem_ack = 1'b0;
            waited     = 0;
         end
      end
   end

   // Register-file write observer.
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst && o_wr_en) begin
            wr_count++;
            last_wr_alu = o_alu_op;
            last_wr_reg = o_write_reg;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b0;
      i_run = 1'b0;
      cyc(2);
      i_rst = 1'b1;
      wr_count = 0;
      cyc(1);
   endtask

   task automatic pulse_run();
      i_run = 1'b1;
      cyc(1);
      i_run = 1'b0;
   endtask

   task automatic fill_mem(input logic [15:0] val);
      for (int a = 0; a < 256; a++) mem[a] = val;
   endtask

   task automatic wait_halt(input int budget);
      int n;
      n = 0;
      while (!o_halted && n < budget) begin
         cyc(1);
         n++;
      end
      chk("halt_reached", {31'd0, o_halted}, 32'd1);
   endtask

   initial begin
      int n_req;
      int n;
      i_rst = 1'b1;
      i_run = 1'b0;
      fill_mem(I_HALT);

      // Reset state
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      chk("rst_pc",       {24'd0, o_pc}, 32'h00);
      chk("rst_req",      {31'd0, o_imem_req}, 32'd0);
      chk("rst_wr_en",    {31'd0, o_wr_en}, 32'd0);
      chk("rst_busy_halt",{30'd0, o_busy, o_halted}, 32'd0);
      chk("rst_errs",     {30'd0, o_err_illegal, o_err_timeout}, 32'd0);
      chk("rst_retired",  {16'd0, o_retired}, 32'd0);
      chk("rst_sel_alu",  {20'd0, o_read_reg1, o_read_reg2, o_write_reg, o_alu_op}, 32'd0);
      cyc(2);
      i_rst = 1'b1;
      cyc(1);
      chk("idle_after_rst", {30'd0, o_imem_req, o_busy}, 32'd0);

      // Single ADD r1,r2->r3 with zero-wait memory
      fill_mem(I_HALT);
      mem[0]    = I_ADD;
      ack_delay = 0;
      wr_count  = 0;
      pulse_run();
      chk("add_c1_req",  {31'd0, o_imem_req}, 32'd1);
      chk("add_c1_busy", {31'd0, o_busy}, 32'd1);
      chk("add_c1_wr",   {31'd0, o_wr_en}, 32'd0);
      cyc(1);
      chk("add_c2_req",  {31'd0, o_imem_req}, 32'd0);
      chk("add_c2_sel",  {23'd0, o_read_reg1, o_read_reg2, o_write_reg}, {23'd0, 3'd1, 3'd2, 3'd3});
      chk("add_c2_wr",   {31'd0, o_wr_en}, 32'd0);
      cyc(1);
      chk("add_c3_alu",  {29'd0, o_alu_op}, 32'd0);
      chk("add_c3_wr",   {31'd0, o_wr_en}, 32'd0);
      cyc(1);
      chk("add_c4_wr",   {31'd0, o_wr_en}, 32'd1);
      chk("add_c4_pc",   {24'd0, o_pc}, 32'h00);
      cyc(1);
      chk("add_c5_wr",   {31'd0, o_wr_en}, 32'd0);
      chk("add_c5_pc",   {24'd0, o_pc}, 32'h01);
      chk("add_c5_ret",  {16'd0, o_retired}, 32'd1);
      wait_halt(20);
      chk("add_wr_count", wr_count, 32'd1);

      // SUB, NOP, XOR, HALT with 2 wait cycles per fetch
      do_reset();
      fill_mem(I_HALT);
      mem[0] = I_SUB; mem[1] = I_NOP; mem[2] = I_XOR; mem[3] = I_HALT;
      ack_delay = 2;
      pulse_run();
      wait_halt(60);
      chk("prog_pc",       {24'd0, o_pc}, 32'h03);
      chk("prog_retired",  {16'd0, o_retired}, 32'd2);
      chk("prog_wr_count", wr_count, 32'd2);
      chk("prog_last_wr",  {26'd0, last_wr_alu, last_wr_reg}, {26'd0, 3'd4, 3'd1});
      chk("prog_busy",     {31'd0, o_busy}, 32'd0);
      pulse_run();
      cyc(4);
      chk("halt_run_ign",  {22'd0, o_halted, o_busy, o_pc}, {22'd0, 1'b1, 1'b0, 8'h03});
      chk("halt_req",      {31'd0, o_imem_req}, 32'd0);

      // Illegal opcode 7'h40
      do_reset();
      fill_mem(I_HALT);
      mem[0]    = I_ILL;
      ack_delay = 0;
      pulse_run();
      wait_halt(30);
      chk("ill_flag",   {30'd0, o_err_illegal, o_err_timeout}, 32'd2);
      chk("ill_pc",     {24'd0, o_pc}, 32'h01);
      chk("ill_wr",     wr_count, 32'd0);
      chk("ill_ret",    {16'd0, o_retired}, 32'd0);

      // Fetch timeout with no ack at all
      do_reset();
      mem_on = 1'b0;
      pulse_run();
      n_req = 0;
      n = 0;
      while (!o_halted && n < 100) begin
         if (o_imem_req) n_req++;
         cyc(1);
         n++;
      end
      chk("to_req_cycles", n_req, 32'd16);
      chk("to_flags",      {29'd0, o_halted, o_err_illegal, o_err_timeout}, {29'd0, 3'b101});
      chk("to_req_off",    {31'd0, o_imem_req}, 32'd0);

      // Ack on the 16th FETCH cycle still decodes normally
      do_reset();
      mem_on = 1'b1;
      fill_mem(I_HALT);
      mem[0]    = I_ADD;
      ack_delay = 15;
      pulse_run();
      wait_halt(100);
      chk("late_ack_err", {31'd0, o_err_timeout}, 32'd0);
      chk("late_ack_ret", {16'd0, o_retired}, 32'd1);
      chk("late_ack_pc",  {24'd0, o_pc}, 32'h01);

      // PC wrap: NOPs up to FE, ADD at FE and FF, HALT at 00
      do_reset();
      fill_mem(I_NOP);
      mem[8'hFE] = I_ADD;
      mem[8'hFF] = I_ADD;
      mem[8'h00] = I_HALT;
      mem[8'h00] = I_NOP;
      ack_delay  = 0;
      pulse_run();
      n = 0;
      while (o_pc != 8'hFE && n < 1000) begin
         cyc(1);
         n++;
      end
      chk("wrap_reach_fe", {24'd0, o_pc}, 32'hFE);
      mem[8'h00] = I_HALT;
      wait_halt(40);
      chk("wrap_pc",      {24'd0, o_pc}, 32'h00);
      chk("wrap_retired", {16'd0, o_retired}, 32'd2);

      // Reset asserted during WB
      do_reset();
      fill_mem(I_HALT);
      mem[0]    = I_SUB;
      ack_delay = 0;
      pulse_run();
      n = 0;
      while (!o_wr_en && n < 20) begin
         cyc(1);
         n++;
      end
      chk("wb_reached", {31'd0, o_wr_en}, 32'd1);
      i_rst = 1'b0;
      #1;
      chk("wbrst_wr",    {31'd0, o_wr_en}, 32'd0);
      chk("wbrst_state", {29'd0, o_busy, o_halted, o_imem_req}, 32'd0);
      chk("wbrst_dp",    {15'd0, o_pc, o_read_reg1, o_alu_op}, 32'd0);
      chk("wbrst_ret",   {16'd0, o_retired}, 32'd0);
      cyc(1);
      i_rst = 1'b1;
      cyc(3);
      chk("wbrst_idle",  {30'd0, o_busy, o_imem_req}, 32'd0);
      pulse_run();
      chk("wbrst_rerun", {23'd0, o_imem_req, o_pc}, {23'd0, 1'b1, 8'h00});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
